// File: rtl/sipo_deser_pkg.sv
// Shared types and helpers for the serial-in, parallel-out deserializer.
package sipo_pkg;

  typedef enum logic {RX_IDLE = 1'b0, RX_SHIFT = 1'b1} rx_state_t;
  typedef enum logic {OUT_EMPTY = 1'b0, OUT_FULL = 1'b1} out_state_t;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/sipo_deser_out_reg.sv
// Valid/ready holding register for completed words; drops a new word and
// pulses overrun when the previous word is still unconsumed.
module sipo_out_reg
  import sipo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             pout_ready,
  output logic [WIDTH-1:0] pout_data,
  output logic             pout_valid,
  output logic             overrun
);

  out_state_t       state_r, state_s;
  logic [WIDTH-1:0] data_r, data_s;
  logic             overrun_r, overrun_s;

  // Next-state, next-data and overrun pulse decode.
  always_comb begin
    state_s   = state_r;
    data_s    = data_r;
    overrun_s = 1'b0;
    if (clear) begin
      state_s = OUT_EMPTY;
    end else begin
      case (state_r)
        OUT_EMPTY: begin
          if (load) begin
            state_s = OUT_FULL;
            data_s  = data;
          end else begin
            state_s = OUT_EMPTY;
          end
        end
        OUT_FULL: begin
          if (load) begin
            if (pout_ready) begin
              data_s = data;
            end else begin
              overrun_s = 1'b1;
            end
          end else if (pout_ready) begin
            state_s = OUT_EMPTY;
          end else begin
            state_s = OUT_FULL;
          end
        end
        default: state_s = OUT_EMPTY;
      endcase
    end
  end

  // Output register state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r   <= OUT_EMPTY;
      data_r    <= {WIDTH{1'b0}};
      overrun_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      data_r    <= data_s;
      overrun_r <= overrun_s;
    end
  end

  assign pout_data  = data_r;
  assign pout_valid = (state_r == OUT_FULL);
  assign overrun    = overrun_r;

endmodule

// File: rtl/sipo_deser.sv
// Serial-in, parallel-out deserializer: assembles WIDTH-bit words from a
// qualified bit stream, restarts on sin_sof, and hands words to sipo_out_reg.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             sin_valid,
  input  logic             sin_data,
  input  logic             sin_sof,
  input  logic             clear,
  output logic [WIDTH-1:0] pout_data,
  output logic             pout_valid,
  input  logic             pout_ready,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err
);

  localparam int            CW       = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);

  rx_state_t        rx_state_r, rx_state_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic [WIDTH-1:0] shreg_r, shreg_s, shifted_s;
  logic             frame_err_r, frame_err_s;
  logic             load_s;

  assign shifted_s = MSB_FIRST ? {shreg_r[WIDTH-2:0], sin_data}
                               : {sin_data, shreg_r[WIDTH-1:1]};

  // Receive FSM next-state, counter and framing decode.
  always_comb begin
    rx_state_s  = rx_state_r;
    cnt_s       = cnt_r;
    shreg_s     = shreg_r;
    frame_err_s = 1'b0;
    load_s      = 1'b0;
    if (clear) begin
      rx_state_s = RX_IDLE;
      cnt_s      = {CW{1'b0}};
    end else if (sin_valid) begin
      shreg_s = shifted_s;
      case (rx_state_r)
        RX_IDLE: begin
          rx_state_s = RX_SHIFT;
          cnt_s      = CNT_ONE;
        end
        RX_SHIFT: begin
          // A restart keeps shifting: the stale bits fall off before completion.
          if (sin_sof) begin
            frame_err_s = 1'b1;
            cnt_s       = CNT_ONE;
          end else if (cnt_r == CNT_LAST) begin
            rx_state_s = RX_IDLE;
            cnt_s      = {CW{1'b0}};
            load_s     = 1'b1;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        default: begin
          rx_state_s = RX_IDLE;
          cnt_s      = {CW{1'b0}};
        end
      endcase
    end else begin
      rx_state_s = rx_state_r;
    end
  end

  // Receive FSM, counter, shift register and frame error pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_state_r  <= RX_IDLE;
      cnt_r       <= {CW{1'b0}};
      shreg_r     <= {WIDTH{1'b0}};
      frame_err_r <= 1'b0;
    end else begin
      rx_state_r  <= rx_state_s;
      cnt_r       <= cnt_s;
      shreg_r     <= shreg_s;
      frame_err_r <= frame_err_s;
    end
  end

  assign busy      = (rx_state_r == RX_SHIFT);
  assign frame_err = frame_err_r;

  sipo_out_reg #(.WIDTH(WIDTH)) u_out_reg (
    .clk        (clk),
    .rstn       (rstn),
    .clear      (clear),
    .load       (load_s),
    .data       (shifted_s),
    .pout_ready (pout_ready),
    .pout_data  (pout_data),
    .pout_valid (pout_valid),
    .overrun    (overrun)
  );

endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench for sipo_deser: an MSB-first and an LSB-first instance share
// the stimulus; a per-cycle vector table plus hand-written corner sequences.
module tb_sipo_deser;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       sin_valid = 1'b0, sin_data = 1'b0, sin_sof = 1'b0, clear = 1'b0;
  logic       pout_ready = 1'b0;
  logic [7:0] m_data, l_data;
  logic       m_valid, l_valid, m_busy, l_busy, m_ovr, l_ovr, m_ferr, l_ferr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rstn(rstn), .sin_valid(sin_valid), .sin_data(sin_data),
    .sin_sof(sin_sof), .clear(clear), .pout_data(m_data), .pout_valid(m_valid),
    .pout_ready(pout_ready), .busy(m_busy), .overrun(m_ovr), .frame_err(m_ferr)
  );

  sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rstn(rstn), .sin_valid(sin_valid), .sin_data(sin_data),
    .sin_sof(sin_sof), .clear(clear), .pout_data(l_data), .pout_valid(l_valid),
    .pout_ready(pout_ready), .busy(l_busy), .overrun(l_ovr), .frame_err(l_ferr)
  );

  typedef struct packed {
    logic       v, d, sof, rdy;
    logic       ev;
    logic [7:0] emsb, elsb;
    logic       ebusy, eferr;
  } vec_t;

  function automatic vec_t mk(logic v, logic d, logic sof, logic rdy, logic ev,
                              logic [7:0] emsb, logic [7:0] elsb, logic ebusy, logic eferr);
    vec_t r;
    r.v = v; r.d = d; r.sof = sof; r.rdy = rdy; r.ev = ev;
    r.emsb = emsb; r.elsb = elsb; r.ebusy = ebusy; r.eferr = eferr;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic d, input logic sof, input logic clr, input logic rdy);
    sin_valid = v; sin_data = d; sin_sof = sof; clear = clr; pout_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w, input logic rdy);
    for (int i = 7; i >= 0; i--) step(1'b1, w[i], 1'b0, 1'b0, rdy);
    sin_valid = 1'b0;
  endtask

  vec_t tbl[20];

  initial begin
    // B2 word, then a framing restart after three bits carrying 0F.
    tbl[0]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    tbl[1]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    tbl[2]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    tbl[3]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    tbl[4]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    tbl[5]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    tbl[6]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    tbl[7]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hB2, 8'h4D, 1'b0, 1'b0);
    tbl[8]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'hB2, 8'h4D, 1'b0, 1'b0);
    tbl[9]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hB2, 8'h4D, 1'b1, 1'b0);
    tbl[10] = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hB2, 8'h4D, 1'b1, 1'b0);
    tbl[11] = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hB2, 8'h4D, 1'b1, 1'b0);
    tbl[12] = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hB2, 8'h4D, 1'b1, 1'b1);
    tbl[13] = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hB2, 8'h4D, 1'b1, 1'b0);
    tbl[14] = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hB2, 8'h4D, 1'b1, 1'b0);
    tbl[15] = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hB2, 8'h4D, 1'b1, 1'b0);
    tbl[16] = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hB2, 8'h4D, 1'b1, 1'b0);
    tbl[17] = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hB2, 8'h4D, 1'b1, 1'b0);
    tbl[18] = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hB2, 8'h4D, 1'b1, 1'b0);
    tbl[19] = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h0F, 8'hF0, 1'b0, 1'b0);

    #3;
    chk("rst_data", {24'h0, m_data}, 32'h0);
    chk("rst_valid", {31'h0, m_valid}, 32'h0);
    chk("rst_busy", {31'h0, m_busy}, 32'h0);
    chk("rst_pulses", {30'h0, m_ovr, m_ferr}, 32'h0);
    chk("rst_lsb_data", {24'h0, l_data}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 20; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].sof, 1'b0, tbl[i].rdy);
      chk($sformatf("tbl%0d_valid", i), {31'h0, m_valid}, {31'h0, tbl[i].ev});
      chk($sformatf("tbl%0d_msb", i), {24'h0, m_data}, {24'h0, tbl[i].emsb});
      chk($sformatf("tbl%0d_lsb", i), {24'h0, l_data}, {24'h0, tbl[i].elsb});
      chk($sformatf("tbl%0d_busy", i), {31'h0, m_busy}, {31'h0, tbl[i].ebusy});
      chk($sformatf("tbl%0d_ferr", i), {31'h0, m_ferr}, {31'h0, tbl[i].eferr});
      chk($sformatf("tbl%0d_ovr", i), {31'h0, m_ovr}, 32'h0);
    end

    // Backpressure: second word dropped, first word held.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("bp_consume0F", {31'h0, m_valid}, 32'h0);
    send_word(8'hB2, 1'b0);
    chk("bp_valid", {31'h0, m_valid}, 32'h1);
    chk("bp_data1", {24'h0, m_data}, 32'hB2);
    chk("bp_noovr", {31'h0, m_ovr}, 32'h0);
    send_word(8'h5A, 1'b0);
    chk("bp_ovr", {31'h0, m_ovr}, 32'h1);
    chk("bp_data2", {24'h0, m_data}, 32'hB2);
    chk("bp_valid2", {31'h0, m_valid}, 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("bp_ovr_once", {31'h0, m_ovr}, 32'h0);
    chk("bp_data3", {24'h0, m_data}, 32'hB2);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("bp_handshake", {31'h0, m_valid}, 32'h0);

    // Gaps: sin_valid toggles; sof/data during gaps must be ignored.
    begin
      logic [7:0] w;
      w = 8'hC3;
      for (int i = 7; i >= 0; i--) begin
        step(1'b0, ~w[i], 1'b1, 1'b0, 1'b1);
        step(1'b1, w[i], 1'b0, 1'b0, 1'b1);
      end
    end
    chk("gap_valid", {31'h0, m_valid}, 32'h1);
    chk("gap_data", {24'h0, m_data}, 32'hC3);
    chk("gap_ferr", {31'h0, m_ferr}, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Clear mid-word with a held word; the bit presented with clear is lost.
    send_word(8'h96, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("clr_busy_pre", {31'h0, m_busy}, 32'h1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("clr_busy", {31'h0, m_busy}, 32'h0);
    chk("clr_valid", {31'h0, m_valid}, 32'h0);
    chk("clr_pulses", {30'h0, m_ovr, m_ferr}, 32'h0);
    send_word(8'h3C, 1'b1);
    chk("clr_fresh_valid", {31'h0, m_valid}, 32'h1);
    chk("clr_fresh_data", {24'h0, m_data}, 32'h3C);

    // Asynchronous reset mid-word with a word held.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ar_busy_pre", {31'h0, m_busy}, 32'h1);
    chk("ar_valid_pre", {31'h0, m_valid}, 32'h1);
    #2;
    rstn = 1'b0;
    #1;
    chk("ar_data", {24'h0, m_data}, 32'h0);
    chk("ar_lsb_data", {24'h0, l_data}, 32'h0);
    chk("ar_valid", {31'h0, m_valid}, 32'h0);
    chk("ar_busy", {31'h0, m_busy}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    send_word(8'hA5, 1'b1);
    chk("ar_after_valid", {31'h0, m_valid}, 32'h1);
    chk("ar_after_data", {24'h0, m_data}, 32'hA5);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ar_after_consume", {31'h0, m_valid}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
